// File: rtl/mux_rr_scheduler.sv
// Round-robin grant scheduler for a shared N:1 data mux with bounded bursts.
// One requester at a time drives the downstream valid/ready port through sel.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; arbitrate from last_ptr+1 when ena and any req
//   GRANT | sel owns the mux; beats flow until req drops or burst ends
module mux_rr_scheduler #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4,
   parameter int SEL_W     = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        sel,
   output logic                    busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [SEL_W-1:0]   sel_nxt;
   logic [SEL_W-1:0]   last_ptr, last_ptr_nxt;
   logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
   logic [SEL_W-1:0]   pick;
   logic               accept;
   logic               last_beat;
   logic [DATA_W-1:0]  data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Walk downward so the candidate closest to last_ptr+1 wins.
   always_comb begin
      pick = last_ptr;
      for (int i = N_REQ; i >= 1; i--) begin
         if (req[SEL_W'((int'(last_ptr) + i) % N_REQ)])
            pick = SEL_W'((int'(last_ptr) + i) % N_REQ);
      end
   end

   assign busy      = (state == GRANT);
   assign out_data  = data_arr[sel];
   assign out_valid = busy & req[sel];
   assign accept    = out_valid & out_ready;
   assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

   always_comb begin
      req_ack = '0;
      if (accept)
         req_ack[sel] = 1'b1;
   end

   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      last_ptr_nxt = last_ptr;
      beat_cnt_nxt = beat_cnt;
      case (state)
         IDLE: begin
            if (ena && (req != '0)) begin
               sel_nxt      = pick;
               beat_cnt_nxt = '0;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            if (accept)
               beat_cnt_nxt = beat_cnt + CNT_W'(1);
            // A dropped request forfeits the grant but still moves the pointer.
            if (!req[sel] || (accept && last_beat)) begin
               state_nxt    = IDLE;
               last_ptr_nxt = sel;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= '0;
         last_ptr <= SEL_W'(N_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         last_ptr <= last_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: latency, round-robin order, backpressure,
// early drop, async reset mid-burst and enable gating.
module tb_mux_rr_scheduler;

   localparam int N_REQ     = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;
   localparam int SEL_W     = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    ena;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ack;
   logic [DATA_W-1:0]       out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        sel;
   logic                    busy;

   int total = 0;
   int bad   = 0;

   mux_rr_scheduler #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .req(req), .req_data(req_data),
      .req_ack(req_ack), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .sel(sel), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int grants [16];
      int gcount;
      int acks_per [N_REQ];
      int cur_acks;
      int n;
      int exp_order [5];
      logic prev_busy;
      logic [0:5] bp_pat;

      exp_order = '{0, 1, 2, 3, 0};
      bp_pat    = 6'b100111;
      rst       = 1'b1;
      ena       = 1'b1;
      req       = '0;
      out_ready = 1'b1;
      req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
      step();
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      chk("rst_ack", req_ack, 0);
      chk("rst_data", out_data, 8'h10);
      rst = 1'b0;
      step();

      // single requester, latency, burst of 4, 1-cycle gap
      req = 4'b0100;
      #1;
      chk("t1_no_valid_yet", out_valid, 0);
      step();
      chk("t1_busy", busy, 1);
      chk("t1_sel", sel, 2);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'hA5);
      n = 0;
      for (int k = 0; k < MAX_BURST; k++) begin
         if (req_ack == 4'b0100) n++;
         step();
      end
      chk("t1_acks", n, 4);
      chk("t1_gap_idle", busy, 0);
      chk("t1_gap_ack", req_ack, 0);
      step();
      chk("t1_regrant", busy, 1);
      req = '0;
      step();
      chk("t1_release", busy, 0);

      // round robin from a fresh reset
      rst = 1'b1;
      #1;
      rst = 1'b0;
      step();
      req = 4'b1111;
      gcount = 0;
      cur_acks = 0;
      prev_busy = 1'b0;
      for (int i = 0; i < N_REQ; i++) acks_per[i] = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (busy && !prev_busy && gcount < 16) begin
            grants[gcount] = int'(sel);
            gcount++;
            cur_acks = 0;
         end
         if (!busy && prev_busy) chk("t2_grant_acks", cur_acks, 4);
         for (int i = 0; i < N_REQ; i++)
            if (req_ack[i]) begin
               acks_per[i]++;
               cur_acks++;
            end
         prev_busy = busy;
      end
      chk("t2_grant_count", gcount, 8);
      for (int i = 0; i < 5; i++) chk("t2_order", grants[i], exp_order[i]);
      for (int i = 0; i < N_REQ; i++) chk("t2_acks_per_req", acks_per[i], 8);
      req = '0;
      step();

      // backpressure on requester 1
      req = 4'b0010;
      step();
      chk("t3_sel", sel, 1);
      n = 0;
      for (int k = 0; k < 6; k++) begin
         out_ready = bp_pat[k];
         #1;
         chk("t3_busy", busy, 1);
         chk("t3_valid", out_valid, 1);
         chk("t3_data", out_data, 8'h21);
         chk("t3_ack", req_ack, bp_pat[k] ? 4'b0010 : 4'b0000);
         if (req_ack[1]) n++;
         step();
      end
      chk("t3_acks", n, 4);
      chk("t3_release", busy, 0);
      req = '0;
      out_ready = 1'b1;
      step();

      // forfeit with no beat, then early drop after 2 beats
      out_ready = 1'b0;
      req = 4'b0001;
      step();
      chk("t4_grant0", sel, 0);
      req = '0;
      step();
      chk("t4_forfeit", busy, 0);
      out_ready = 1'b1;
      req = 4'b0010;
      step();
      chk("t4_sel1", sel, 1);
      n = 0;
      for (int k = 0; k < 2; k++) begin
         if (req_ack == 4'b0010) n++;
         step();
      end
      chk("t4_two_beats", n, 2);
      req = 4'b0101;
      #1;
      chk("t4_drop_valid", out_valid, 0);
      step();
      chk("t4_drop_idle", busy, 0);
      req = 4'b0111;
      step();
      chk("t4_next_sel", sel, 2);
      chk("t4_next_busy", busy, 1);
      req = '0;
      step();
      step();

      // async reset during beat 2 of requester 3
      req = 4'b1000;
      step();
      chk("t5_sel3", sel, 3);
      step();
      #1;
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_sel", sel, 0);
      chk("t5_rst_data", out_data, 8'h10);
      req = 4'b1111;
      rst = 1'b0;
      step();
      chk("t5_first_sel", sel, 0);
      chk("t5_first_busy", busy, 1);
      req = '0;
      step();
      step();

      // enable gating
      ena = 1'b0;
      req = 4'b0001;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (busy) n++;
      end
      chk("t6_no_grant", n, 0);
      ena = 1'b1;
      step();
      chk("t6_grant", busy, 1);
      ena = 1'b0;
      n = 0;
      for (int k = 0; k < 10 && busy; k++) begin
         #1;
         if (req_ack[0]) n++;
         step();
      end
      chk("t6_burst_done", n, 4);
      chk("t6_idle", busy, 0);
      n = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (busy) n++;
      end
      chk("t6_blocked", n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
